// File: rtl/csd_digit_streamer_if.sv
// Operand/digit handshake bundle for csd_digit_streamer.
// slave is the streamer's view, master is the producer/consumer view.
interface csd_digit_streamer_if #(
    parameter int W  = 4,
    parameter int PW = $clog2(W)
);
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic          in_skip;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_digit;
    logic [PW-1:0] out_pos;
    logic          out_last;

    modport slave (
        input  in_valid, in_x, in_skip, out_ready,
        output in_ready, out_valid, out_digit, out_pos, out_last
    );

    modport master (
        output in_valid, in_x, in_skip, out_ready,
        input  in_ready, out_valid, out_digit, out_pos, out_last
    );
endinterface

// File: rtl/csd_digit_streamer.sv
// Recodes two's-complement operands to CSD and streams the digits one per beat,
// either every position or only the non-zero ones (skip mode).

module bin2csd #(
    parameter int W = 4
) (
    input  logic [W-1:0]   x_i,
    output logic [2*W-1:0] csd_o
);
    logic [W:0]   xe;
    logic [W-1:0] c;

    assign xe   = {x_i[W-1], x_i};
    assign c[0] = 1'b0;

    // A digit is non-zero when x_i + c_i is odd; its sign is the next input bit.
    genvar gi;
    generate
        for (gi = 0; gi < W - 1; gi++) begin : g_carry
            assign c[gi+1] = (xe[gi] & c[gi]) | ((xe[gi] ^ c[gi]) & xe[gi+1]);
        end
        for (gi = 0; gi < W; gi++) begin : g_digit
            assign csd_o[2*gi]   = xe[gi] ^ c[gi];
            assign csd_o[2*gi+1] = (xe[gi] ^ c[gi]) & xe[gi+1];
        end
    endgenerate
endmodule

module csd_digit_streamer #(
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b1,
    parameter int PW        = $clog2(W)
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  flush,
    output logic                  busy,
    csd_digit_streamer_if.slave   bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [PW-1:0] FIRST_POS = MSB_FIRST ? PW'(W - 1) : '0;
    localparam logic [PW-1:0] LAST_POS  = MSB_FIRST ? '0 : PW'(W - 1);

    state_t         state_q;
    logic [2*W-1:0] csd_q;
    logic           skip_q;
    logic [PW-1:0]  ptr_q;
    logic [W-1:0]   mask_q;

    logic [2*W-1:0] csd_d;
    logic [W-1:0]   nz_d;
    logic [W-1:0]   ptr_oh;
    logic [W-1:0]   mask_rest;
    logic [PW-1:0]  ptr_d;
    logic [1:0]     digit_sel;
    logic           last_w;
    logic           fire_out;
    logic           accept;

    // Next position in stream order among the set bits of m; 0 when m is empty.
    function automatic logic [PW-1:0] pick(input logic [W-1:0] m);
        logic [PW-1:0] p;
        p = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < W; i++) if (m[i]) p = PW'(i);
        end else begin
            for (int i = W - 1; i >= 0; i--) if (m[i]) p = PW'(i);
        end
        return p;
    endfunction

    bin2csd #(.W(W)) u_bin2csd (
        .x_i   (bus.in_x),
        .csd_o (csd_d)
    );

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_mask
            assign nz_d[gi]   = csd_d[2*gi];
            assign ptr_oh[gi] = (ptr_q == PW'(gi));
        end
    endgenerate

    always_comb begin
        digit_sel = 2'b00;
        for (int i = 0; i < W; i++) begin
            if (ptr_oh[i]) digit_sel = csd_q[2*i +: 2];
        end
    end

    assign mask_rest = mask_q & ~ptr_oh;
    assign ptr_d     = skip_q    ? pick(mask_rest)
                     : MSB_FIRST ? ptr_q - PW'(1)
                     :             ptr_q + PW'(1);

    assign busy     = (state_q == STREAM);
    assign last_w   = busy & (skip_q ? (mask_rest == '0) : (ptr_q == LAST_POS));
    assign fire_out = busy & bus.out_ready;
    // arst_n gating keeps in_ready low while the block is held in reset.
    assign bus.in_ready  = arst_n & (~busy | (fire_out & last_w));
    assign accept        = bus.in_valid & bus.in_ready & ~flush;

    assign bus.out_valid = busy;
    assign bus.out_digit = busy ? digit_sel : 2'b00;
    assign bus.out_pos   = ptr_q;
    assign bus.out_last  = last_w;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            csd_q   <= '0;
            skip_q  <= 1'b0;
            ptr_q   <= '0;
            mask_q  <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            csd_q   <= '0;
            skip_q  <= 1'b0;
            ptr_q   <= '0;
            mask_q  <= '0;
        end else if (accept) begin
            state_q <= STREAM;
            csd_q   <= csd_d;
            skip_q  <= bus.in_skip;
            mask_q  <= nz_d;
            ptr_q   <= bus.in_skip ? pick(nz_d) : FIRST_POS;
        end else if (fire_out) begin
            if (last_w) begin
                state_q <= IDLE;
                csd_q   <= '0;
                ptr_q   <= '0;
                mask_q  <= '0;
            end else begin
                ptr_q   <= ptr_d;
                mask_q  <= mask_rest;
            end
        end
    end
endmodule

// File: doc/csd_digit_streamer.md
# csd_digit_streamer

Sequencer around one `bin2csd` instance in the xfire FPU BKM datapath. It accepts W-bit two's-complement operands over a valid/ready handshake and recodes each one to canonical signed digit (CSD) form. It registers the CSD word and streams the digits one per beat, MSB-first or LSB-first, to the BKM shift-add stages. In skip mode it emits only the non-zero digits with their positions, so the consumer can issue one add/sub per beat.

## Interface
- `W`, 4: operand width. This is also the number of CSD digits. Must be ≥2.
- `MSB_FIRST`, 1: digit order. 1 streams position W-1 down to 0; 0 streams position 0 up to W-1.
- `PW`, $clog2(W): width of `out_pos`. Derived; do not override.
- `clk`  in  1  single clock, rising edge.
- `arst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous abort of the current operand.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  operand accepted when `in_valid & in_ready` at a rising edge.
- `in_x`  in  W  two's-complement operand.
- `in_skip`  in  1  skip-zero mode, sampled together with `in_x`.
- `out_valid`  out  1  digit beat valid.
- `out_ready`  in  1  consumer takes the beat when `out_valid & out_ready`.
- `out_digit`  out  2  digit encoding: 00 = 0, 01 = +1, 11 = −1. 10 is never driven.
- `out_pos`  out  PW  weight index of `out_digit`, so the digit is worth digit·2^pos.
- `out_last`  out  1  final beat of the operand.
- `busy`  out  1  an operand is held (state STREAM).

## Operation
- Datapath: `bin2csd` #(W) recodes `in_x` combinationally. On accept, the block registers the 2W-bit CSD word, a copy of `in_skip`, and the starting position.
- Digit i of the CSD word is bits [2i+1:2i].
- The CSD word contains no two adjacent non-zero digits.
- State machine:
  - IDLE: `in_ready`=1, `out_valid`=0. Accept → STREAM.
  - STREAM: `out_valid`=1. Each output handshake advances the pointer.
  - Handshake with `out_last`=1: go to IDLE, or reload immediately if a new operand is accepted in the same cycle.
- `in_ready` = (state==IDLE) | (`out_valid` & `out_ready` & `out_last`). This gives back-to-back operands with no bubble.
- Full mode (`in_skip`=0): exactly W beats. Positions run in strict order and `out_last` is asserted at the final position (0 when MSB-first, W−1 when LSB-first).
- Skip mode (`in_skip`=1):
  - Only non-zero digits are emitted, in the configured order.
  - The next position comes from a priority encoder over the remaining non-zero mask, and no cycles are spent on zero digits.
  - `out_last` = no non-zero digit remains after the current one.
  - An operand of 0 produces exactly one beat: pos 0, digit 00, `out_last`=1.
- `out_digit`, `out_pos` and `out_last` are driven from registers plus the pointer only, with no combinational path from the `in_*` ports.
- `flush`=1 at an edge returns the block to IDLE, discards the held word and suppresses any accept in that cycle. `flush` has priority over all other events.

## Timing
- Reset (`arst_n`=0):
  - state IDLE, `out_valid`=0, `busy`=0, `out_digit`=00, `out_pos`=0, `out_last`=0.
  - `in_ready` is forced to 0 while `arst_n` is low and reads 1 from the first cycle after release.
- Latency: an operand accepted at edge k puts its first beat on the outputs in cycle k+1.
- Throughput: W cycles per operand in full mode, and max(1, number of non-zero digits) cycles per operand in skip mode, when `out_ready`=1.
- Backpressure: while `out_valid` & !`out_ready`, `out_digit`, `out_pos` and `out_last` hold stable and `in_ready`=0.
- Reset asserted mid-stream: outputs go to their reset values immediately (asynchronous). No beat survives the reset.
- Flush: `out_valid`=0 in the cycle after the flush edge.

## Test plan
- Full mode, MSB_FIRST=1, W=4, x=4'b0111 (+7), `out_ready`=1 → beats (pos3,01), (pos2,00), (pos1,00), (pos0,11,last). The CSD word is 8'b01000011. The first beat appears one cycle after accept.
- Skip mode, x=+7 → 2 beats: (pos3,01), (pos0,11,last). Then x=0 → one beat (pos0,00,last).
- Skip mode, back-to-back x=4'b1011 (−5) then 4'b1000 (−8), `in_valid` held, `out_ready`=1 → (pos2,11), (pos0,11,last), (pos3,11,last) with no idle cycle between them. `in_ready` is high only in IDLE and in the cycle of each last beat.
- Backpressure: full mode x=+5, drop `out_ready` for 3 cycles on beat pos2 → (pos2,01) is held unchanged and `in_ready`=0 throughout. The sequence then completes (pos1,00), (pos0,01,last).
- Flush and reset:
  - Flush during beat pos1 of x=+7 → `out_valid`=0 on the next cycle and an `in_valid` offered in the flush cycle is not accepted.
  - Repeat with `arst_n` pulsed low instead → the outputs show the reset values immediately.
  - The next operand then streams correctly.
- LSB-first (MSB_FIRST=0), exhaustive over all 16 values of x in both modes → the sum of digit·2^pos over the emitted beats equals the signed value of x. Skip mode never emits a zero digit except for x=0, and full mode emits exactly W beats.
